// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer and the pipeline registers it drives.
// Holds the sequencer state encoding, the flush NOP and a counter width helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'b00,
    ST_RUN      = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_t;

  // addi x0, x0, 0 -- loaded by the IF/ID and ID/EX flush muxes
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that stops at MAX instead of wrapping; CLR wins over INC.
// One-cycle update on the rising edge, cleared by the async reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_n,
  input  logic         CLR,
  input  logic         INC,
  input  logic [W-1:0] MAX,
  output logic [W-1:0] Q
);

  logic [W-1:0] r_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_q <= '0;
    end else if (CLR) begin
      r_q <= '0;
    end else if (INC && (r_q < MAX)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stage sequencer: per-stage enables/flushes from HDU, BPU and data-memory handshake,
// post-reset datapath clear, sticky memory timeout and saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RST_CYC = 4,
  parameter int MEM_TO  = 15,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             HDU_STALL,
  input  logic             BPU_MISSPRED,
  input  logic             MEM_REQ,
  input  logic             MEM_READY,
  output logic             PC_EN,
  output logic             IF_ID_EN,
  output logic             ID_EX_EN,
  output logic             EX_MEM_EN,
  output logic             MEM_WB_EN,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             DP_RST,
  output logic             MEM_ERR,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam int IW = cnt_width(RST_CYC - 1);
  localparam int WW = cnt_width(MEM_TO);

  state_t       r_state;
  state_t       w_next;
  logic         r_pend_mp;
  logic         r_mem_err;
  logic [IW-1:0] w_init_q;
  logic [WW-1:0] w_wait_q;

  logic w_in_init;
  logic w_in_run;
  logic w_in_wait;
  logic w_mem_stall;
  logic w_init_done;
  logic w_wait_inc;
  logic w_wait_clr;
  logic w_release;
  logic w_stall_inc;

  assign w_in_init   = (r_state == ST_INIT);
  assign w_in_run    = (r_state == ST_RUN);
  assign w_in_wait   = (r_state == ST_MEM_WAIT);
  assign w_mem_stall = MEM_REQ & ~MEM_READY;
  assign w_init_done = w_in_init && (w_init_q == IW'(RST_CYC - 1));
  assign w_release   = w_in_wait & MEM_READY;
  assign w_wait_inc  = (w_in_run & w_mem_stall) | (w_in_wait & ~MEM_READY);
  assign w_wait_clr  = w_release;
  assign w_stall_inc = ~w_in_init & ~PC_EN;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT:     if (w_init_done) w_next = ST_RUN;
      ST_RUN:      if (w_mem_stall) w_next = ST_MEM_WAIT;
      ST_MEM_WAIT: if (MEM_READY)   w_next = ST_RUN;
      default:     w_next = ST_INIT;
    endcase
  end

  always_comb begin
    PC_EN       = 1'b0;
    IF_ID_EN    = 1'b0;
    ID_EX_EN    = 1'b0;
    EX_MEM_EN   = 1'b0;
    MEM_WB_EN   = 1'b0;
    IF_ID_FLUSH = 1'b0;
    ID_EX_FLUSH = 1'b0;
    DP_RST      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!w_mem_stall) begin
          ID_EX_EN  = 1'b1;
          EX_MEM_EN = 1'b1;
          MEM_WB_EN = 1'b1;
          if (BPU_MISSPRED) begin
            PC_EN       = 1'b1;
            IF_ID_EN    = 1'b1;
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
          end else if (HDU_STALL) begin
            ID_EX_FLUSH = 1'b1;
          end else begin
            PC_EN    = 1'b1;
            IF_ID_EN = 1'b1;
          end
        end
      end
      ST_MEM_WAIT: begin
        // A misprediction seen at any point of the wait is squashed on release.
        if (MEM_READY) begin
          ID_EX_EN  = 1'b1;
          EX_MEM_EN = 1'b1;
          MEM_WB_EN = 1'b1;
          if (r_pend_mp || BPU_MISSPRED) begin
            PC_EN       = 1'b1;
            IF_ID_EN    = 1'b1;
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
          end else if (HDU_STALL) begin
            ID_EX_FLUSH = 1'b1;
          end else begin
            PC_EN    = 1'b1;
            IF_ID_EN = 1'b1;
          end
        end
      end
      default: begin
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
        DP_RST      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_pend_mp <= 1'b0;
    end else if (w_release) begin
      r_pend_mp <= 1'b0;
    end else if (w_wait_inc && BPU_MISSPRED) begin
      r_pend_mp <= 1'b1;
    end
  end

  // Raised on the edge where the wait counter reaches MEM_TO.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_mem_err <= 1'b0;
    end else if (w_in_wait && !MEM_READY && (w_wait_q >= WW'(MEM_TO - 1))) begin
      r_mem_err <= 1'b1;
    end
  end

  assign MEM_ERR = r_mem_err;

  sat_counter #(.W(IW)) u_init_cnt (
    .CLK   (CLK),
    .RST_n (RST_n),
    .CLR   (1'b0),
    .INC   (w_in_init),
    .MAX   (IW'(RST_CYC - 1)),
    .Q     (w_init_q)
  );

  sat_counter #(.W(WW)) u_wait_cnt (
    .CLK   (CLK),
    .RST_n (RST_n),
    .CLR   (w_wait_clr),
    .INC   (w_wait_inc),
    .MAX   (WW'(MEM_TO)),
    .Q     (w_wait_q)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST_n (RST_n),
    .CLR   (1'b0),
    .INC   (w_stall_inc),
    .MAX   ({CNT_W{1'b1}}),
    .Q     (STALL_CNT)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two parameterisations driven by shared stimulus, each checked
// every cycle against a behavioural model, with directed literal checks up front.
module tb_pipe_ctrl;

  localparam int M_INIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;

  typedef struct {
    int st;
    int icnt;
    int j;
    bit pend;
    bit err;
    int scnt;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n, hdu, mp, req, rdy;

  logic pc0, ifid0, idex0, exm0, mwb0, iff0, idf0, dp0, err0;
  logic pc1, ifid1, idex1, exm1, mwb1, iff1, idf1, dp1, err1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  logic [7:0]  ctl0, ctl1;

  assign ctl0 = {pc0, ifid0, idex0, exm0, mwb0, iff0, idf0, dp0};
  assign ctl1 = {pc1, ifid1, idex1, exm1, mwb1, iff1, idf1, dp1};

  pipe_ctrl #(.RST_CYC(4), .MEM_TO(15), .CNT_W(16)) u_dut (
    .CLK(clk), .RST_n(rst_n), .HDU_STALL(hdu), .BPU_MISSPRED(mp),
    .MEM_REQ(req), .MEM_READY(rdy),
    .PC_EN(pc0), .IF_ID_EN(ifid0), .ID_EX_EN(idex0), .EX_MEM_EN(exm0), .MEM_WB_EN(mwb0),
    .IF_ID_FLUSH(iff0), .ID_EX_FLUSH(idf0), .DP_RST(dp0), .MEM_ERR(err0), .STALL_CNT(cnt0)
  );

  pipe_ctrl #(.RST_CYC(2), .MEM_TO(3), .CNT_W(4)) u_dut4 (
    .CLK(clk), .RST_n(rst_n), .HDU_STALL(hdu), .BPU_MISSPRED(mp),
    .MEM_REQ(req), .MEM_READY(rdy),
    .PC_EN(pc1), .IF_ID_EN(ifid1), .ID_EX_EN(idex1), .EX_MEM_EN(exm1), .MEM_WB_EN(mwb1),
    .IF_ID_FLUSH(iff1), .ID_EX_FLUSH(idf1), .DP_RST(dp1), .MEM_ERR(err1), .STALL_CNT(cnt1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit done  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic mdl_t mreset();
    mdl_t m;
    m.st = M_INIT; m.icnt = 0; m.j = 0; m.pend = 0; m.err = 0; m.scnt = 0;
    return m;
  endfunction

  // {PC,IF_ID,ID_EX,EX_MEM,MEM_WB enables, IF_ID_FLUSH, ID_EX_FLUSH, DP_RST}
  function automatic logic [7:0] mctl(mdl_t m, bit h, bit b, bit q, bit r);
    if (m.st == M_INIT) return 8'b00000_111;
    if (m.st == M_RUN) begin
      if (q && !r) return 8'b00000_000;
      if (b)       return 8'b11111_110;
      if (h)       return 8'b00111_010;
      return 8'b11111_000;
    end
    if (!r)            return 8'b00000_000;
    if (m.pend || b)   return 8'b11111_110;
    if (h)             return 8'b00111_010;
    return 8'b11111_000;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int rc, int mto, int cmax,
                                 bit h, bit b, bit q, bit r);
    mdl_t nm;
    logic [7:0] c;
    nm = m;
    c  = mctl(m, h, b, q, r);
    if (m.st != M_INIT && !c[7] && m.scnt < cmax) nm.scnt = m.scnt + 1;
    case (m.st)
      M_INIT: begin
        nm.icnt = m.icnt + 1;
        if (nm.icnt == rc) nm.st = M_RUN;
      end
      M_RUN: begin
        if (q && !r) begin
          nm.st = M_WAIT; nm.j = 1; nm.pend = b;
        end
      end
      default: begin
        if (!r) begin
          nm.j = m.j + 1;
          if (b) nm.pend = 1;
          if (nm.j >= mto) nm.err = 1;
        end else begin
          nm.st = M_RUN; nm.pend = 0;
        end
      end
    endcase
    return nm;
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    mdl_t m0, m1;
    m0 = mreset();
    m1 = mreset();
    while (!done) begin
      @(negedge clk);
      if (!rst_n) begin
        m0 = mreset();
        m1 = mreset();
      end
      chk("ctl_a", {24'd0, ctl0}, {24'd0, mctl(m0, hdu, mp, req, rdy)});
      chk("err_a", {31'd0, err0}, {31'd0, m0.err});
      chk("cnt_a", {16'd0, cnt0}, m0.scnt);
      chk("ctl_b", {24'd0, ctl1}, {24'd0, mctl(m1, hdu, mp, req, rdy)});
      chk("err_b", {31'd0, err1}, {31'd0, m1.err});
      chk("cnt_b", {28'd0, cnt1}, m1.scnt);
      if (rst_n) begin
        m0 = mstep(m0, 4, 15, 65535, hdu, mp, req, rdy);
        m1 = mstep(m1, 2, 3, 15, hdu, mp, req, rdy);
      end
    end
  end

  task automatic drive(input bit h, input bit b, input bit q, input bit r);
    hdu = h; mp = b; req = q; rdy = r;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    hdu = 0; mp = 0; req = 0; rdy = 0;
    repeat (3) tick();
    chk("rst_dp", {31'd0, dp0}, 32'd1);
    chk("rst_ctl", {24'd0, ctl0}, 32'h07);
    chk("rst_cnt", {16'd0, cnt0}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0);
      chk("init_ctl", {24'd0, ctl0}, 32'h07);
      tick();
    end
    drive(0, 0, 0, 0);
    chk("run_ctl", {24'd0, ctl0}, 32'hF8);
    chk("run_cnt", {16'd0, cnt0}, 32'd0);
    tick();

    drive(1, 0, 0, 0);
    chk("hdu_ctl", {24'd0, ctl0}, 32'h3A);
    tick();
    drive(0, 0, 0, 0);
    chk("hdu_cnt", {16'd0, cnt0}, 32'd1);
    tick();

    drive(1, 1, 0, 0);
    chk("mp_ctl", {24'd0, ctl0}, 32'hFE);
    tick();
    drive(0, 0, 0, 0);
    chk("mp_cnt", {16'd0, cnt0}, 32'd1);
    tick();

    drive(0, 0, 1, 0); chk("mw1_ctl", {24'd0, ctl0}, 32'h00); tick();
    drive(0, 1, 1, 0); chk("mw2_ctl", {24'd0, ctl0}, 32'h00); tick();
    drive(0, 0, 1, 0); chk("mw3_ctl", {24'd0, ctl0}, 32'h00); tick();
    drive(0, 0, 1, 1); chk("mw_rel", {24'd0, ctl0}, 32'hFE); tick();
    drive(0, 0, 0, 0);
    chk("mw_cnt", {16'd0, cnt0}, 32'd4);
    chk("mw_run", {24'd0, ctl0}, 32'hF8);
    tick();

    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 0);
      if (i == 14) chk("to_pre", {31'd0, err0}, 32'd0);
      if (i == 15) chk("to_set", {31'd0, err0}, 32'd1);
      tick();
    end
    drive(0, 0, 1, 1); tick();
    drive(0, 0, 0, 0);
    chk("to_hold", {31'd0, err0}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("to_clr", {31'd0, err0}, 32'd0);
    chk("to_dp", {31'd0, dp0}, 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0);
      tick();
    end

    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    chk("sat_b", {28'd0, cnt1}, 32'd15);
    chk("sat_a", {16'd0, cnt0}, 32'd20);
    tick();

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      hdu = ($urandom_range(0, 3) == 0);
      mp  = ($urandom_range(0, 6) == 0);
      req = ($urandom_range(0, 9) < 3);
      rdy = ($urandom_range(0, 9) < ((i % 500) < 250 ? 5 : 1));
      tick();
    end
    rst_n = 1'b1;

    done = 1;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline stage sequencer for the 5-stage RISC-V core (IF/ID/EX/MEM/WB). It turns the HDU stall, the BPU misprediction and the data-memory handshake into per-stage register enables and flush (bubble) controls. It also runs the post-reset datapath flush and keeps a stall-cycle performance counter. It sits between the CU/HDU/BPU and the pipeline registers, and replaces the ad-hoc enable gating in the CU.

Parameters:
RST_CYC, 4, number of cycles DP_RST is held after reset release (must be >= 1)
MEM_TO, 15, MEM_WAIT cycles after which MEM_ERR is raised (must be >= 1)
CNT_W, 16, width of STALL_CNT

Ports:
CLK  in  1  core clock, rising edge
RST_n  in  1  reset, asynchronous, active-low
HDU_STALL  in  1  load-use hazard from HDU; bubble into EX
BPU_MISSPRED  in  1  branch resolved wrong in EX this cycle
MEM_REQ  in  1  load or store occupying the MEM stage
MEM_READY  in  1  data memory completes the access this cycle
PC_EN  out  1  PC register load enable
IF_ID_EN  out  1  IF/ID register enable
ID_EX_EN  out  1  ID/EX register enable
EX_MEM_EN  out  1  EX/MEM register enable
MEM_WB_EN  out  1  MEM/WB register enable
IF_ID_FLUSH  out  1  load NOP into IF/ID
ID_EX_FLUSH  out  1  load NOP (controls zeroed) into ID/EX
DP_RST  out  1  synchronous datapath clear request
MEM_ERR  out  1  sticky memory timeout flag
STALL_CNT  out  CNT_W  saturating count of cycles with PC_EN=0 in RUN or MEM_WAIT

Behaviour:
- One clock. Reset is asynchronous and active-low. Async reset sets: state=INIT, init counter=0, wait counter=0, pend_mp=0, MEM_ERR=0, STALL_CNT=0.
- Outputs during reset and INIT: all *_EN=0, both FLUSH=1, DP_RST=1.
- States: INIT, RUN, MEM_WAIT. Outputs are Mealy (state + current inputs), zero latency. All registers update on the rising edge of CLK.
- INIT: the init counter increments every cycle. When it reaches RST_CYC-1, go to RUN. DP_RST=1 for exactly RST_CYC cycles after RST_n rises. All inputs are ignored in INIT.
- RUN: conditions below are listed in priority order, highest first.
  - Memory stall (MEM_REQ=1 and MEM_READY=0): all EN=0, FLUSH=0. Go to MEM_WAIT with wait counter=1. If BPU_MISSPRED=1 in the same cycle, set pend_mp=1.
  - Misprediction (BPU_MISSPRED=1): all EN=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1. HDU_STALL is ignored in this cycle.
  - Load-use stall (HDU_STALL=1): PC_EN=0, IF_ID_EN=0, ID_EX_EN=1, ID_EX_FLUSH=1, EX_MEM_EN=1, MEM_WB_EN=1.
  - Otherwise: all EN=1, FLUSH=0.
- MEM_WAIT, MEM_READY=0: all EN=0, FLUSH=0. The wait counter increments and saturates at MEM_TO. When the counter equals MEM_TO, MEM_ERR is set and stays set until reset. The state remains MEM_WAIT.
- MEM_WAIT, MEM_READY=1 (release cycle):
  - All EN=1.
  - If pend_mp=1: both FLUSH=1, then clear pend_mp.
  - Else apply HDU_STALL exactly as in RUN.
  - Return to RUN and clear the wait counter.
- BPU_MISSPRED arriving while in MEM_WAIT sets pend_mp; it is never lost.
- Simultaneous MEM_REQ=1 and MEM_READY=1 in RUN is a normal single-cycle access with no state change.
- STALL_CNT increments on every cycle where PC_EN=0 and state≠INIT. It saturates at 2^CNT_W-1 and never wraps.
- Reset asserted mid-operation (any state): async return to INIT, pending flush discarded.

Decomposition:
- Shared package/include `pipe_ctrl_pkg`: state encodings (INIT=2'b00, RUN=2'b01, MEM_WAIT=2'b10) and a NOP instruction constant (32'h00000013) used by the flush muxes in the pipeline registers.
- One sub-module: `sat_counter` (parameter W, ports CLK, RST_n, CLR, INC, MAX, Q). Instantiated for the init counter, the wait counter and STALL_CNT.

Test Plan:
1. Reset release with RST_CYC=4 -> DP_RST=1 for 4 cycles, both FLUSH=1 and all EN=0 during them; cycle 5 is RUN with all EN=1 and STALL_CNT=0.
2. HDU_STALL=1 for one cycle in RUN -> PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1, EX_MEM_EN=1; STALL_CNT goes 0->1.
3. BPU_MISSPRED=1 and HDU_STALL=1 together -> IF_ID_FLUSH=1, ID_EX_FLUSH=1, PC_EN=1; STALL_CNT unchanged.
4. MEM_REQ=1 with MEM_READY=0 for 3 cycles, BPU_MISSPRED=1 in the 2nd, READY in the 4th -> 3 cycles all EN=0; release cycle all EN=1 with both FLUSH=1; STALL_CNT=3; back in RUN.
5. MEM_REQ=1 with MEM_READY held 0 for 20 cycles, MEM_TO=15 -> MEM_ERR rises after the 15th wait cycle and stays 1 after READY. RST_n pulse clears it to 0 and returns to INIT.
6. CNT_W=4 with 20 consecutive HDU stalls -> STALL_CNT saturates at 15 and holds.
